// File: rtl/dac_frame_serializer.sv
// dac_frame_serializer
// Captures a 16-bit DAC frame (control byte + data byte) on a sample tick and
// shifts it out MSB-first as two 8-bit bursts. Each burst is announced by a
// one-cycle LD_pdata pulse. The bursts are separated by GAP_CYCLES idle cycles.
// Every output is a register of the current state, so outputs trail the state
// by one cycle. This gives a fixed 1-cycle tick-to-LD_pdata latency.
module dac_frame_serializer #(
  parameter int GAP_CYCLES = 2  // idle cycles between the two bytes, 1..15
) (
  input  logic       clk,
  input  logic       RST_N,
  input  logic       tick,
  input  logic [7:0] ctrl_byte,
  input  logic [7:0] data_byte,
  output logic       LD_pdata,
  output logic       sdata,
  output logic       shift_en,
  output logic       busy,
  output logic       frame_done,
  output logic       tick_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_HI,
    SHIFT_HI,
    GAP,
    LOAD_LO,
    SHIFT_LO,
    DONE
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] hold;       // {ctrl, data} frozen for the whole frame
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic [3:0]  gap_cnt;
  logic        ovr_flag;   // sticky overrun, mirrored to tick_overrun
  logic        accept;
  logic        shifting;

  // A tick starts a frame only from IDLE or DONE; anywhere else it is an overrun.
  assign accept   = tick && ((state == IDLE) || (state == DONE));
  assign shifting = (state == SHIFT_HI) || (state == SHIFT_LO);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode for the frame sequence.
  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt; a missing
    // branch would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE:     if (tick) state_nxt = LOAD_HI;
      LOAD_HI:  state_nxt = SHIFT_HI;
      SHIFT_HI: if (bit_cnt == 3'd7) state_nxt = GAP;
      GAP:      if (gap_cnt == GAP_LAST) state_nxt = LOAD_LO;
      LOAD_LO:  state_nxt = SHIFT_LO;
      SHIFT_LO: if (bit_cnt == 3'd7) state_nxt = DONE;
      DONE:     state_nxt = tick ? LOAD_HI : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Datapath: frame capture, shift register, bit/gap counters, overrun flag.
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      hold     <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      ovr_flag <= 1'b0;
    end else begin
      if (accept) hold <= {ctrl_byte, data_byte};

      case (state)
        LOAD_HI: begin
          shreg   <= hold[15:8];
          bit_cnt <= '0;
        end
        LOAD_LO: begin
          shreg   <= hold[7:0];
          bit_cnt <= '0;
        end
        SHIFT_HI, SHIFT_LO: begin
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
        default: ;
      endcase

      // Gap counter runs only inside GAP and restarts from 0 on every entry.
      gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;

      if (tick && !accept) ovr_flag <= 1'b1;
    end
  end

  // Output registers, decoded from the current state.
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      LD_pdata     <= 1'b0;
      sdata        <= 1'b0;
      shift_en     <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      LD_pdata     <= (state == LOAD_HI) || (state == LOAD_LO);
      shift_en     <= shifting;
      sdata        <= shifting ? shreg[7] : 1'b0;
      busy         <= (state != IDLE);
      frame_done   <= (state == DONE);
      tick_overrun <= ovr_flag;
    end
  end

endmodule

// File: tb/tb_dac_frame_serializer.sv
// Testbench for dac_frame_serializer.
// Three instances: G=2 (main), G=1 and G=15 (share a separate tick).
// Stimulus pushes per-cycle expected output records into a per-instance queue.
// A negedge monitor pops and compares one record for each cycle in which the
// instance shows any activity.
module tb_dac_frame_serializer;

  logic       clk = 1'b0;
  logic       RST_N;
  logic       tick;
  logic       tick_x;
  logic [7:0] ctrl_byte;
  logic [7:0] data_byte;

  logic ld_o[3], sd_o[3], se_o[3], busy_o[3], fd_o[3], ov_o[3];

  always #5 clk = ~clk;

  dac_frame_serializer #(.GAP_CYCLES(2)) u_g2 (
    .clk(clk), .RST_N(RST_N), .tick(tick),
    .ctrl_byte(ctrl_byte), .data_byte(data_byte),
    .LD_pdata(ld_o[0]), .sdata(sd_o[0]), .shift_en(se_o[0]),
    .busy(busy_o[0]), .frame_done(fd_o[0]), .tick_overrun(ov_o[0])
  );

  dac_frame_serializer #(.GAP_CYCLES(1)) u_g1 (
    .clk(clk), .RST_N(RST_N), .tick(tick_x),
    .ctrl_byte(ctrl_byte), .data_byte(data_byte),
    .LD_pdata(ld_o[1]), .sdata(sd_o[1]), .shift_en(se_o[1]),
    .busy(busy_o[1]), .frame_done(fd_o[1]), .tick_overrun(ov_o[1])
  );

  dac_frame_serializer #(.GAP_CYCLES(15)) u_g15 (
    .clk(clk), .RST_N(RST_N), .tick(tick_x),
    .ctrl_byte(ctrl_byte), .data_byte(data_byte),
    .LD_pdata(ld_o[2]), .sdata(sd_o[2]), .shift_en(se_o[2]),
    .busy(busy_o[2]), .frame_done(fd_o[2]), .tick_overrun(ov_o[2])
  );

  typedef struct packed {
    logic ld;
    logic se;
    logic sd;
    logic done;
    logic busy;
    logic ovr;
  } rec_t;

  rec_t exp_q[3][$];
  rec_t mon_act;
  rec_t mon_exp;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected records for cycles c1..cN of a frame started at E0 with gap g.
  task automatic push_frame(input int idx, input int g, input logic [7:0] c,
                            input logic [7:0] d, input int n, input int ovr_from);
    rec_t r;
    for (int k = 1; k <= n; k++) begin
      r      = '0;
      r.busy = 1'b1;
      r.ld   = (k == 1) || (k == 10 + g);
      r.se   = (k >= 2 && k <= 9) || (k >= 11 + g && k <= 18 + g);
      if (k >= 2 && k <= 9)              r.sd = c[3'(9 - k)];
      else if (k >= 11 + g && k <= 18 + g) r.sd = d[3'(18 + g - k)];
      r.done = (k == 19 + g);
      r.ovr  = (k >= ovr_from);
      exp_q[idx].push_back(r);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present tick for exactly one edge (E0); returns in c0.
  task automatic start_frame();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  function automatic logic [5:0] outs(input int i);
    return {ld_o[i], se_o[i], sd_o[i], fd_o[i], busy_o[i], ov_o[i]};
  endfunction

  // Scoreboard monitor: one record per active cycle per instance.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      mon_act = outs(i);
      if ((mon_act.ld | mon_act.se | mon_act.sd | mon_act.done | mon_act.busy) === 1'b1) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("dut%0d unexpected activity {ld,se,sd,done,busy,ovr}", i),
                32'(mon_act), 32'(0));
        end else begin
          mon_exp = exp_q[i].pop_front();
          check($sformatf("dut%0d {ld,se,sd,done,busy,ovr}", i),
                32'(mon_act), 32'(mon_exp));
        end
      end
    end
  end

  initial begin
    RST_N     = 1'b0;
    tick      = 1'b1;
    tick_x    = 1'b1;
    ctrl_byte = 8'h00;
    data_byte = 8'h00;

    // Reset with tick held: everything stays quiet.
    step(3);
    for (int i = 0; i < 3; i++) check($sformatf("dut%0d reset outputs", i), 32'(outs(i)), 32'(0));
    tick   = 1'b0;
    tick_x = 1'b0;
    RST_N  = 1'b1;
    step(2);

    // Basic frame 03/A5: LD in c1/c12, done in c21, busy low in c22.
    ctrl_byte = 8'h03;
    data_byte = 8'hA5;
    push_frame(0, 2, 8'h03, 8'hA5, 21, 999);
    start_frame();
    step(22);
    check("basic busy low c22", 32'(busy_o[0]), 32'(0));
    check("basic queue drained", 32'(exp_q[0].size()), 32'(0));

    // Inputs change to FF at c5: the stream must stay 03/A5.
    push_frame(0, 2, 8'h03, 8'hA5, 21, 999);
    start_frame();
    step(5);
    ctrl_byte = 8'hFF;
    data_byte = 8'hFF;
    step(17);
    check("capture queue drained", 32'(exp_q[0].size()), 32'(0));

    // Overrun at E7, then back-to-back tick at E21 with new bytes 5C/3E.
    ctrl_byte = 8'h03;
    data_byte = 8'hA5;
    push_frame(0, 2, 8'h03, 8'hA5, 21, 8);
    push_frame(0, 2, 8'h5C, 8'h3E, 21, 0);
    start_frame();
    step(6);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    check("overrun not yet c7", 32'(ov_o[0]), 32'(0));
    step(1);
    check("overrun set c8", 32'(ov_o[0]), 32'(1));
    ctrl_byte = 8'h5C;
    data_byte = 8'h3E;
    step(12);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(22);
    check("b2b busy low", 32'(busy_o[0]), 32'(0));
    check("b2b overrun sticky", 32'(ov_o[0]), 32'(1));
    check("b2b queue drained", 32'(exp_q[0].size()), 32'(0));

    // Reset at E15: frame abandoned, all outputs 0 from c15.
    ctrl_byte = 8'h81;
    data_byte = 8'h7E;
    push_frame(0, 2, 8'h81, 8'h7E, 14, 0);
    start_frame();
    step(14);
    RST_N = 1'b0;
    step(1);
    check("midreset outputs c15", 32'(outs(0)), 32'(0));
    RST_N = 1'b1;
    step(25);
    check("midreset no frame_done", 32'(exp_q[0].size()), 32'(0));
    check("midreset overrun cleared", 32'(ov_o[0]), 32'(0));

    // Clean frame after the abandoned one.
    ctrl_byte = 8'h96;
    data_byte = 8'h69;
    push_frame(0, 2, 8'h96, 8'h69, 21, 999);
    start_frame();
    step(22);
    check("post-reset busy low", 32'(busy_o[0]), 32'(0));
    check("post-reset queue drained", 32'(exp_q[0].size()), 32'(0));

    // G=1 and G=15: second LD in c11/c25, frame_done in c20/c34.
    ctrl_byte = 8'hC3;
    data_byte = 8'h5A;
    push_frame(1, 1,  8'hC3, 8'h5A, 20, 999);
    push_frame(2, 15, 8'hC3, 8'h5A, 34, 999);
    tick_x = 1'b1;
    step(1);
    tick_x = 1'b0;
    step(35);
    check("g1 queue drained",  32'(exp_q[1].size()), 32'(0));
    check("g15 queue drained", 32'(exp_q[2].size()), 32'(0));
    check("g1 busy low",  32'(busy_o[1]), 32'(0));
    check("g15 busy low", 32'(busy_o[2]), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
